// File: rtl/gcd_dispatch.sv
// gcd_dispatch: buffers operand pairs in a small circular FIFO and feeds them,
// one at a time, to an external GCD engine. The engine result is held on the
// downstream port, together with the operands that produced it, until accepted.
//
// state | meaning
// IDLE  | no operation in flight; pops the FIFO head when one is present
// ISSUE | operands loaded; eng_start is high for this cycle only
// WAIT  | engine busy; waiting for eng_done
// HOLD  | result presented (out_valid = 1) until out_ready
module gcd_dispatch #(
  parameter int nbits = 32,
  parameter int depth = 4   // power of 2, at least 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [nbits-1:0]       in_a,
  input  logic [nbits-1:0]       in_b,
  output logic [nbits-1:0]       eng_a,
  output logic [nbits-1:0]       eng_b,
  output logic                   eng_start,
  input  logic [nbits-1:0]       eng_result,
  input  logic                   eng_done,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [nbits-1:0]       out_result,
  output logic [nbits-1:0]       out_a,
  output logic [nbits-1:0]       out_b,
  output logic [$clog2(depth):0] level
);

  localparam int PW = $clog2(depth);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL = LW'(depth);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  state_t           r_state;
  logic [nbits-1:0] r_mem_a [depth];
  logic [nbits-1:0] r_mem_b [depth];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic [nbits-1:0] r_op_a;
  logic [nbits-1:0] r_op_b;
  logic [nbits-1:0] r_out_result;
  logic             r_eng_start;
  logic             r_out_valid;

  logic             w_push;
  logic             w_pop;

  // in_ready depends only on the registered level, never on in_valid
  assign in_ready = (r_level != FULL);
  assign w_push   = in_valid && in_ready;
  // the FSM is the only consumer and only pops from IDLE with data present
  assign w_pop    = (r_state == IDLE) && (r_level != '0);

  // FIFO storage; contents need no reset because level gates every read
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr] <= in_a;
      r_mem_b[r_wr_ptr] <= in_b;
    end
  end

  // FIFO pointers and occupancy; power-of-2 depth makes pointer wrap free
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // dispatch FSM with registered engine and downstream outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_out_result <= '0;
      r_eng_start  <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_op_a      <= r_mem_a[r_rd_ptr];
            r_op_b      <= r_mem_b[r_rd_ptr];
            r_eng_start <= 1'b1;
            r_state     <= ISSUE;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          // eng_done is only meaningful here; elsewhere it is ignored
          if (eng_done) begin
            r_out_result <= eng_result;
            r_out_valid  <= 1'b1;
            r_state      <= HOLD;
          end
        end
        HOLD: begin
          // going back through IDLE guarantees two cycles between
          // eng_done and the next eng_start
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign eng_a      = r_op_a;
  assign eng_b      = r_op_b;
  assign eng_start  = r_eng_start;
  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_a      = r_op_a;
  assign out_b      = r_op_b;
  assign level      = r_level;

endmodule

// File: tb/tb_gcd_dispatch.sv
// tb_gcd_dispatch: directed vectors plus hand-written multi-cycle sequences
// for gcd_dispatch, with a small behavioural GCD engine attached.
module tb_gcd_dispatch;
  localparam int NB    = 32;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int ENG_LAT = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [NB-1:0] in_a, in_b;
  logic [NB-1:0] eng_a, eng_b;
  logic          eng_start;
  logic [NB-1:0] eng_result = '0;
  logic          eng_done = 1'b0;
  logic          out_valid;
  logic          out_ready;
  logic [NB-1:0] out_result, out_a, out_b;
  logic [LW-1:0] level;

  int n_vec = 0;
  int n_bad = 0;

  // engine-side bookkeeping (written only by the engine process)
  int start_cnt = 0;
  int served = 0;
  // main-process requests to the engine
  int req_done = 0;
  bit eng_noise = 1'b0;

  always #5 clk = ~clk;

  gcd_dispatch #(.nbits(NB), .depth(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .eng_a(eng_a), .eng_b(eng_b), .eng_start(eng_start),
    .eng_result(eng_result), .eng_done(eng_done),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_a(out_a), .out_b(out_b),
    .level(level)
  );

  function automatic logic [NB-1:0] gcd_f(input logic [NB-1:0] a, input logic [NB-1:0] b);
    logic [NB-1:0] x, y, t;
    x = a;
    y = b;
    while (y != 0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // behavioural engine: ENG_LAT cycles after eng_start, one-cycle eng_done
  initial begin : engine
    int pending;
    logic [NB-1:0] la, lb;
    pending = 0;
    la = '0;
    lb = '0;
    forever begin
      @(posedge clk);
      #1;
      eng_done = 1'b0;
      if (!reset_n) begin
        pending = 0;
      end else begin
        if (eng_start) begin
          start_cnt++;
          la = eng_a;
          lb = eng_b;
          pending = ENG_LAT;
        end else if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            eng_result = gcd_f(la, lb);
            eng_done = 1'b1;
          end
        end else if (req_done != served) begin
          served++;
          eng_done = 1'b1;
        end
        if (eng_noise && !eng_done) eng_result = eng_result ^ 32'hA5A5_0F0F;
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int t;
    t = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("push_timeout_in_ready", in_ready, 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name, input logic [NB-1:0] ea,
                          input logic [NB-1:0] eb, input logic [NB-1:0] er);
    int t;
    t = 0;
    while (!out_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    check({name, "_valid"}, out_valid, 1);
    if (out_valid) begin
      check({name, "_result"}, out_result, er);
      check({name, "_a"}, out_a, ea);
      check({name, "_b"}, out_b, eb);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NB-1:0] a;
    logic [NB-1:0] b;
    logic [NB-1:0] res;
  } vec_t;

  vec_t vecs [9];
  vec_t fill [6];

  initial begin : main
    int t, idx, s0;
    bit acc, prev_done, seen;

    vecs[0] = '{32'd48,  32'd18,  32'd6};
    vecs[1] = '{32'd0,   32'd7,   32'd7};
    vecs[2] = '{32'd7,   32'd0,   32'd7};
    vecs[3] = '{32'd0,   32'd0,   32'd0};
    vecs[4] = '{32'd21,  32'd14,  32'd7};
    vecs[5] = '{32'd17,  32'd5,   32'd1};
    vecs[6] = '{32'd100, 32'd75,  32'd25};
    vecs[7] = '{32'd12,  32'd12,  32'd12};
    vecs[8] = '{32'hFFFF_FFFF, 32'h0000_FFFF, 32'h0000_FFFF};

    fill[0] = '{32'd10, 32'd4,  32'd2};
    fill[1] = '{32'd9,  32'd6,  32'd3};
    fill[2] = '{32'd8,  32'd12, 32'd4};
    fill[3] = '{32'd15, 32'd25, 32'd5};
    fill[4] = '{32'd14, 32'd21, 32'd7};
    fill[5] = '{32'd99, 32'd33, 32'd33};

    reset_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_level", level, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_eng_start", eng_start, 0);
    check("rst_out_result", out_result, 0);
    check("rst_eng_a", eng_a, 0);
    check("rst_eng_b", eng_b, 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    // latency: push at edge N, eng_start in the cycle after edge N+1
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'd48;
    in_b = 32'd18;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("lat_start_early", eng_start, 0);
    check("lat_level_after_push", level, 1);
    @(negedge clk);
    check("lat_start", eng_start, 1);
    check("lat_eng_a", eng_a, 48);
    check("lat_eng_b", eng_b, 18);
    check("lat_level_after_pop", level, 0);
    @(negedge clk);
    check("lat_start_one_cycle", eng_start, 0);
    t = 0;
    prev_done = 1'b0;
    while (!out_valid && t < 50) begin
      prev_done = eng_done;
      @(negedge clk);
      t++;
    end
    check("lat_out_valid", out_valid, 1);
    check("lat_done_to_valid", prev_done, 1);
    check("lat_result", out_result, 6);
    check("lat_out_a", out_a, 48);
    check("lat_out_b", out_b, 18);
    @(negedge clk);
    check("lat_valid_one_cycle", out_valid, 0);

    // table vectors, one at a time
    for (int i = 0; i < 9; i++) begin
      push(vecs[i].a, vecs[i].b);
      wait_out($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].res);
    end

    // back-to-back zero operands, each with its own start
    s0 = start_cnt;
    push(32'd0, 32'd7);
    push(32'd0, 32'd0);
    wait_out("b2b_first", 32'd0, 32'd7, 32'd7);
    wait_out("b2b_second", 32'd0, 32'd0, 32'd0);
    check("b2b_starts", start_cnt - s0, 2);

    // fill with downstream stalled: one pair in the op regs, depth in FIFO
    out_ready = 1'b0;
    s0 = start_cnt;
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = fill[idx].a;
      in_b = fill[idx].b;
      acc = in_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("fill_accepted", idx, DEPTH + 1);
    check("fill_in_ready", in_ready, 0);
    check("fill_level", level, DEPTH);
    check("fill_one_start", start_cnt - s0, 1);
    check("fill_holding", out_valid, 1);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++)
      wait_out($sformatf("drain%0d", i), fill[i].a, fill[i].b, fill[i].res);
    repeat (10) @(negedge clk);
    check("drain_level", level, 0);
    check("drain_no_extra", out_valid, 0);
    check("drain_starts", start_cnt - s0, DEPTH + 1);

    // result held stable in HOLD while eng_result wanders
    out_ready = 1'b0;
    push(32'd48, 32'd18);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("hold_valid", out_valid, 1);
    eng_noise = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check($sformatf("hold_result_c%0d", c), out_result, 6);
    end
    check("hold_still_valid", out_valid, 1);
    eng_noise = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_one_transfer", out_valid, 0);
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("hold_no_second", seen, 0);
    out_ready = 1'b1;

    // push on the pop cycle at level 1: level stays 1
    s0 = start_cnt;
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 32'd30;
    in_b = 32'd12;
    @(posedge clk);
    @(negedge clk);
    check("pp_level_before", level, 1);
    in_a = 32'd21;
    in_b = 32'd14;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("pp_level_same", level, 1);
    check("pp_start", eng_start, 1);
    check("pp_eng_a", eng_a, 30);
    wait_out("pp_first", 32'd30, 32'd12, 32'd6);
    wait_out("pp_second", 32'd21, 32'd14, 32'd7);
    check("pp_starts", start_cnt - s0, 2);

    // reset during WAIT, stale eng_done afterwards is ignored
    push(32'd9, 32'd3);
    push(32'd5, 32'd5);
    @(negedge clk);
    @(negedge clk);
    check("rw_level_pre", level, 1);
    check("rw_busy_pre", eng_start | out_valid, 0);
    reset_n = 1'b0;
    #1;
    check("rw_async_level", level, 0);
    check("rw_async_valid", out_valid, 0);
    check("rw_async_eng_a", eng_a, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    s0 = start_cnt;
    req_done = req_done + 1;
    seen = 1'b0;
    prev_done = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
      if (eng_done) prev_done = 1'b1;
    end
    check("rw_done_seen", prev_done, 1);
    check("rw_no_valid", seen, 0);
    check("rw_level", level, 0);
    check("rw_in_ready", in_ready, 1);
    check("rw_no_start", start_cnt - s0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/gcd_dispatch.md
GCD_DISPATCH -- requirements
Module: gcd_dispatch

Interface
REQ-001 SHALL have parameter nbits, default 32, operand and result width.
REQ-002 SHALL have parameter depth, default 4, operand FIFO entries; a power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1): upstream operand-pair handshake.
REQ-006 SHALL have ports in_a and in_b, input, nbits each: the operand pair.
REQ-007 SHALL have ports eng_a and eng_b, output, nbits each: operands to the GCD engine.
REQ-008 SHALL have port eng_start, output, 1: single-cycle start pulse to the engine.
REQ-009 SHALL have ports eng_result (input, nbits) and eng_done (input, 1): engine result and single-cycle completion flag.
REQ-010 SHALL have ports out_valid (input out_ready, 1): downstream result handshake; out_valid is an output, out_ready an input.
REQ-011 SHALL have ports out_result, out_a and out_b, output, nbits each: the GCD result and the echoed operands.
REQ-012 SHALL have port level, output, $clog2(depth)+1 bits: current FIFO occupancy.

Function
REQ-013 SHALL hold operand pairs in a circular FIFO of depth entries; read/write pointers wrap modulo depth.
REQ-014 SHALL drive in_ready = (level != depth) from registered state only; a push occurs when in_valid && in_ready.
REQ-015 SHALL leave level unchanged on a same-cycle push and pop; SHALL never pop when empty or push when full.
REQ-016 SHALL implement FSM states IDLE, ISSUE, WAIT, HOLD.
REQ-017 IDLE: if level != 0, SHALL pop the head into registers op_a/op_b and go to ISSUE; otherwise SHALL stay in IDLE.
REQ-018 ISSUE: SHALL assert eng_start for exactly this cycle, then go to WAIT.
REQ-019 SHALL drive eng_a = op_a and eng_b = op_b continuously.
REQ-020 WAIT: on eng_done, SHALL register eng_result into out_result, set out_valid, and go to HOLD; otherwise SHALL stay in WAIT.
REQ-021 HOLD: SHALL keep out_valid = 1 and out_result/out_a/out_b stable until out_ready; on out_valid && out_ready, SHALL clear out_valid and go to IDLE.
REQ-022 SHALL drive out_a = op_a and out_b = op_b.
REQ-023 SHALL ignore eng_done in any state other than WAIT.
REQ-024 Latency: for an empty idle block with out_ready = 1, a push at edge N SHALL give eng_start high in cycle N+2, and out_valid high 1 cycle after eng_done.
REQ-025 SHALL issue a new eng_start no earlier than 2 cycles after eng_done, so the engine has returned to its idle state.
REQ-026 SHALL allow pushes in every state, including while in WAIT or HOLD.
REQ-027 SHALL pass results through unmodified, including zero operands.

Reset
REQ-028 On reset_n low, SHALL immediately and asynchronously clear to: state IDLE, pointers 0, level 0, out_valid 0, eng_start 0, out_result/op_a/op_b 0.
REQ-029 After reset_n is deasserted, SHALL have in_ready = 1.
REQ-030 SHALL discard FIFO contents and any in-flight operation on reset; an eng_done arriving after reset SHALL be ignored.
REQ-031 reset_n SHALL be shared with the downstream GCD engine.

Verification
REQ-032 Push (48,18) into an idle block with out_ready = 1 -> eng_start pulses 2 cycles after the push; out_valid with out_result = 6, out_a = 48, out_b = 18 for one cycle.
REQ-033 Hold out_ready = 0 and push pairs continuously -> depth+1 pairs accepted (one in op regs, depth in FIFO); in_ready = 0 and level = depth; no second eng_start.
REQ-034 Push (0,7) and (0,0) back-to-back -> results 7 then 0 in push order, each after its own eng_start/eng_done pair.
REQ-035 Hold out_ready low 10 cycles in HOLD, changing eng_result meanwhile -> out_result stays stable; then a one-cycle out_ready completes exactly one transfer.
REQ-036 At level = 1 in IDLE, push on the pop cycle -> level stays 1; the pair (21,14) yields 7 after the current one.
REQ-037 Assert reset_n low during WAIT, then pulse eng_done after release -> out_valid stays 0, level = 0, in_ready = 1, no eng_start.
